execution_mdu: RTL and testbench

- Iterative multiply/divide unit with HI/LO registers, attached beside the ALU in the execution stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the issue pipeline.
- Multi-cycle ops raise a stall request until complete.
- Parametrised in data width and bits retired per cycle (radix); supports abort on pipeline flush.

---
 rtl/execution_mdu_pkg.sv | 31 +++
 rtl/mdu_step.sv | 48 ++++
 rtl/execution_mdu.sv | 157 +++++++++++++++
 tb/tb_execution_mdu.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/execution_mdu_pkg.sv
// rtl/execution_mdu_pkg.sv - op codes, FSM states and decode helpers for the multiply/divide unit
// Contents:
//   MDU_OP_WIDTH  width of the op field
//   mdu_op_e      op codes accepted from the issue pipeline
//   mdu_state_e   IDLE / CALC / FIX sequencer states
//   is_muldiv()   true for the multi-cycle ops (MULT, MULTU, DIV, DIVU)
package execution_mdu_pkg;

  localparam int MDU_OP_WIDTH = 3;

  typedef enum logic [MDU_OP_WIDTH-1:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic is_muldiv(input logic [MDU_OP_WIDTH-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - combinational STEP-bit iteration of shift-add multiply / restoring divide
// Ports:
//   is_div   1 selects restoring divide, 0 selects shift-add multiply
//   acc_in   accumulator before the iteration
//            multiply: {partial product high half, remaining multiplier bits}
//            divide:   {partial remainder, remaining dividend bits / quotient bits}
//   operand  multiplicand (multiply) or divisor (divide), both magnitudes
//   acc_out  accumulator after STEP single-bit iterations
module mdu_step #(
  parameter int DATA_WIDTH = 32,
  parameter int STEP       = 1
) (
  input  logic                      is_div,
  input  logic [2*DATA_WIDTH-1:0]   acc_in,
  input  logic [DATA_WIDTH-1:0]     operand,
  output logic [2*DATA_WIDTH-1:0]   acc_out
);

  localparam int W = DATA_WIDTH;

  logic [2*W-1:0] a;
  logic [W:0]     sum;
  logic [W:0]     diff;

  always_comb begin
    a    = acc_in;
    sum  = '0;
    diff = '0;
    for (int i = 0; i < STEP; i++) begin
      if (is_div) begin
        // Trial subtract of the divisor from the remainder shifted left by one
        // with the next dividend bit; a clear sign bit means it fits.
        diff = {a[2*W-1:W], a[W-1]} - {1'b0, operand};
        if (!diff[W]) begin
          a = {diff[W-1:0], a[W-2:0], 1'b1};
        end else begin
          a = {a[2*W-2:0], 1'b0};
        end
      end else begin
        // Carry out of the add lands in the top bit as the product shifts right.
        sum = {1'b0, a[2*W-1:W]} + (a[0] ? {1'b0, operand} : '0);
        a   = {sum, a[W-1:1]};
      end
    end
    acc_out = a;
  end

endmodule

// File: rtl/execution_mdu.sv
// rtl/execution_mdu.sv - iterative multiply/divide unit with HI/LO registers for the execution stage
// Ports:
//   clk, rst   clock (rising edge) and asynchronous active-high reset
//   flush      kills any in-flight op; outranks start and the final HI/LO write
//   start, op  op valid this cycle and its code (mdu_op_e)
//   rs, rt     dividend/multiplicand/MTHI-MTLO source and divisor/multiplier
//   stall_req  combinational hold request to the upstream pipeline
//   busy       registered, high while a mul/div is in flight
//   done       registered one-cycle pulse when a mul/div has just written HI/LO
//   hi, lo     architectural HI and LO registers
module execution_mdu
  import execution_mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STEP       = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    start,
  input  logic [MDU_OP_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]   rs,
  input  logic [DATA_WIDTH-1:0]   rt,
  output logic                    stall_req,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   hi,
  output logic [DATA_WIDTH-1:0]   lo
);

  localparam int W     = DATA_WIDTH;
  localparam int N     = DATA_WIDTH / STEP;
  localparam int CNT_W = $clog2(N + 1);

  mdu_state_e       state, next_state;
  logic             is_div;
  logic             div_zero;
  logic             neg_q;     // product / quotient must be negated
  logic             neg_r;     // remainder takes the (negative) dividend sign
  logic [W-1:0]     opnd;      // multiplicand, divisor, or raw rs for divide-by-zero
  logic [2*W-1:0]   acc;
  logic [2*W-1:0]   acc_next;
  logic [CNT_W-1:0] cnt;

  logic             op_muldiv;
  logic             op_signed;
  logic             op_isdiv;
  logic             accept;
  logic [W-1:0]     abs_rs;
  logic [W-1:0]     abs_rt;
  logic [2*W-1:0]   prod_fix;
  logic [W-1:0]     quo_fix;
  logic [W-1:0]     rem_fix;

  assign op_muldiv = is_muldiv(op);
  assign op_signed = (op == MDU_MULT) || (op == MDU_DIV);
  assign op_isdiv  = (op == MDU_DIV) || (op == MDU_DIVU);
  assign accept    = start && !flush && (state == MDU_IDLE);

  // Magnitudes for signed ops; MIN stays MIN, which reads correctly as unsigned.
  assign abs_rs = (op_signed && rs[W-1]) ? -rs : rs;
  assign abs_rt = (op_signed && rt[W-1]) ? -rt : rt;

  assign stall_req = busy | (start & op_muldiv & ~flush);

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[W-1:0] : acc[W-1:0];
  assign rem_fix  = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];

  mdu_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .STEP       (STEP)
  ) u_step (
    .is_div  (is_div),
    .acc_in  (acc),
    .operand (opnd),
    .acc_out (acc_next)
  );

  always_comb begin
    next_state = state;
    case (state)
      MDU_IDLE: begin
        if (start && !flush && op_muldiv) begin
          next_state = (op_isdiv && rt == '0) ? MDU_FIX : MDU_CALC;
        end
      end
      MDU_CALC: begin
        if (flush) begin
          next_state = MDU_IDLE;
        end else if (cnt == CNT_W'(N - 1)) begin
          next_state = MDU_FIX;
        end
      end
      MDU_FIX:  next_state = MDU_IDLE;
      default:  next_state = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MDU_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state != MDU_IDLE);
      done  <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (accept && op == MDU_MTHI) hi <= rs;
          if (accept && op == MDU_MTLO) lo <= rs;
          if (accept && op_muldiv) begin
            is_div   <= op_isdiv;
            div_zero <= op_isdiv && (rt == '0);
            neg_q    <= op_signed && (rs[W-1] ^ rt[W-1]);
            neg_r    <= (op == MDU_DIV) && rs[W-1];
            opnd     <= (op_isdiv && rt == '0) ? rs : (op_isdiv ? abs_rt : abs_rs);
            acc      <= {{W{1'b0}}, (op_isdiv ? abs_rs : abs_rt)};
            cnt      <= '0;
          end
        end
        MDU_CALC: begin
          if (!flush) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
          end
        end
        MDU_FIX: begin
          if (!flush) begin
            done <= 1'b1;
            if (div_zero) begin
              lo <= '1;
              hi <= opnd;
            end else if (is_div) begin
              lo <= quo_fix;
              hi <= rem_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_execution_mdu.sv
// tb/tb_execution_mdu.sv - directed self-checking bench for execution_mdu (STEP=1 and STEP=4)
module tb_execution_mdu;
  import execution_mdu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, flush1, start1, stall1, busy1, done1;
  logic [2:0]  op1;
  logic [31:0] rs1, rt1, hi1, lo1;
  logic        rst4, flush4, start4, stall4, busy4, done4;
  logic [2:0]  op4;
  logic [31:0] rs4, rt4, hi4, lo4;

  int tests = 0;
  int fails = 0;

  execution_mdu #(.DATA_WIDTH(32), .STEP(1)) u_dut1 (
    .clk(clk), .rst(rst1), .flush(flush1), .start(start1), .op(op1),
    .rs(rs1), .rt(rt1), .stall_req(stall1), .busy(busy1), .done(done1),
    .hi(hi1), .lo(lo1)
  );

  execution_mdu #(.DATA_WIDTH(32), .STEP(4)) u_dut4 (
    .clk(clk), .rst(rst4), .flush(flush4), .start(start4), .op(op4),
    .rs(rs4), .rt(rt4), .stall_req(stall4), .busy(busy4), .done(done4),
    .hi(hi4), .lo(lo4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit w4, input bit s, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    if (w4) begin
      start4 = s; op4 = o; rs4 = a; rt4 = b;
    end else begin
      start1 = s; op1 = o; rs1 = a; rt1 = b;
    end
  endtask

  function automatic logic busy_of(input bit w4);  return w4 ? busy4  : busy1;  endfunction
  function automatic logic stall_of(input bit w4); return w4 ? stall4 : stall1; endfunction
  function automatic logic done_of(input bit w4);  return w4 ? done4  : done1;  endfunction
  function automatic logic [31:0] hi_of(input bit w4); return w4 ? hi4 : hi1; endfunction
  function automatic logic [31:0] lo_of(input bit w4); return w4 ? lo4 : lo1; endfunction

  // Issue one mul/div, count busy cycles at negedges, then check HI/LO and the done pulse.
  // With poke set, extra starts are driven while busy and must be ignored.
  task automatic run(input string tag, input bit w4, input logic [2:0] o,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el,
                     input int ebusy, input bit poke);
    int n;
    bit stall_ok;
    bit done_early;
    n = 0; stall_ok = 1'b1; done_early = 1'b0;
    @(negedge clk);
    drive(w4, 1'b1, o, a, b);
    #1;
    check({tag, " stall@start"}, 64'(stall_of(w4)), 64'd1);
    @(negedge clk);
    drive(w4, 1'b0, MDU_NOP, '0, '0);
    while (busy_of(w4) && n < 200) begin
      n++;
      if (!stall_of(w4)) stall_ok = 1'b0;
      if (done_of(w4)) done_early = 1'b1;
      if (poke && n == 3)      drive(w4, 1'b1, MDU_MTHI, 32'hDEAD, '0);
      else if (poke && n == 4) drive(w4, 1'b1, MDU_MULTU, 32'd7, 32'd7);
      else                     drive(w4, 1'b0, MDU_NOP, '0, '0);
      @(negedge clk);
    end
    drive(w4, 1'b0, MDU_NOP, '0, '0);
    check({tag, " busy_cycles"}, 64'(n), 64'(ebusy));
    check({tag, " stall_while_busy"}, 64'(stall_ok), 64'd1);
    check({tag, " no_early_done"}, 64'(done_early), 64'd0);
    check({tag, " done"}, 64'(done_of(w4)), 64'd1);
    check({tag, " hi"}, 64'(hi_of(w4)), 64'(eh));
    check({tag, " lo"}, 64'(lo_of(w4)), 64'(el));
    @(negedge clk);
    check({tag, " done_pulse_end"}, 64'(done_of(w4)), 64'd0);
  endtask

  initial begin
    int dcount;
    rst1 = 1'b1; flush1 = 1'b0; start1 = 1'b0; op1 = MDU_NOP; rs1 = '0; rt1 = '0;
    rst4 = 1'b1; flush4 = 1'b0; start4 = 1'b0; op4 = MDU_NOP; rs4 = '0; rt4 = '0;
    #1;
    check("reset hi",    64'(hi1),    64'd0);
    check("reset lo",    64'(lo1),    64'd0);
    check("reset busy",  64'(busy1),  64'd0);
    check("reset done",  64'(done1),  64'd0);
    check("reset stall", 64'(stall1), 64'd0);
    repeat (2) @(negedge clk);
    rst1 = 1'b0; rst4 = 1'b0;

    run("mult",     1'b0, MDU_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 33, 1'b0);
    run("divu",     1'b0, MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33, 1'b0);
    run("div_neg",  1'b0, MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0);
    run("div_ovf",  1'b0, MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33, 1'b0);
    run("divu_z",   1'b0, MDU_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1,  1'b0);

    // MTHI then MTLO back to back: single-cycle, no busy/done.
    @(negedge clk);
    drive(1'b0, 1'b1, MDU_MTHI, 32'h1234, '0);
    #1;
    check("mthi stall", 64'(stall1), 64'd0);
    @(negedge clk);
    drive(1'b0, 1'b1, MDU_MTLO, 32'h5678, '0);
    check("mthi hi", 64'(hi1), 64'h1234);
    check("mthi busy", 64'(busy1), 64'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, MDU_NOP, '0, '0);
    check("mtlo lo", 64'(lo1), 64'h5678);
    check("mtlo hi", 64'(hi1), 64'h1234);
    check("mtlo busy", 64'(busy1), 64'd0);
    check("mtlo done", 64'(done1), 64'd0);

    // Flush in the 10th CALC cycle.
    @(negedge clk);
    drive(1'b0, 1'b1, MDU_MULTU, 32'h12345678, 32'h9);
    @(negedge clk);
    drive(1'b0, 1'b0, MDU_NOP, '0, '0);
    repeat (9) @(negedge clk);
    check("flush precond busy", 64'(busy1), 64'd1);
    flush1 = 1'b1;
    @(negedge clk);
    flush1 = 1'b0;
    #1;
    check("flush busy", 64'(busy1), 64'd0);
    check("flush stall", 64'(stall1), 64'd0);
    check("flush hi", 64'(hi1), 64'h1234);
    check("flush lo", 64'(lo1), 64'h5678);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done1) dcount++;
    end
    check("flush no_done", 64'(dcount), 64'd0);
    check("flush hi_later", 64'(hi1), 64'h1234);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    drive(1'b0, 1'b1, MDU_MULTU, 32'd3, 32'd5);
    @(negedge clk);
    drive(1'b0, 1'b0, MDU_NOP, '0, '0);
    repeat (5) @(negedge clk);
    check("rstmid precond busy", 64'(busy1), 64'd1);
    rst1 = 1'b1;
    #1;
    check("rstmid hi",   64'(hi1),   64'd0);
    check("rstmid lo",   64'(lo1),   64'd0);
    check("rstmid busy", 64'(busy1), 64'd0);
    check("rstmid done", 64'(done1), 64'd0);
    @(negedge clk);
    rst1 = 1'b0;

    // Radix-16 instance.
    run("s4 multu", 1'b1, MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 9, 1'b1);
    run("s4 mult",  1'b1, MDU_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 9, 1'b0);
    run("s4 divu",  1'b1, MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       9, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
